dds_multi: RTL and testbench

- Multi-channel direct digital synthesiser: per-channel phase accumulators, phase offsets and waveform modes.
- One shared quarter-wave sine ROM is time-multiplexed across channels by a small sequencer.
- Output codes are offset binary and feed the DAC/PWM stage; all channels update together on one sample strobe.

---
 rtl/dds_multi.sv | 200 ++++++++++++++++++++
 tb/tb_dds_multi.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_multi.sv
// Multi-channel DDS: per-channel phase accumulators feeding one shared, time-multiplexed
// quarter-wave sine ROM; all channels present a new offset-binary sample on one strobe.
module dds_multi #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned PHASE_WIDTH   = 32,
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned CHANNELS      = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic                            phase_reset,
  input  logic [CHANNELS*PHASE_WIDTH-1:0] ftw,
  input  logic [CHANNELS*PHASE_WIDTH-1:0] phase_offset,
  input  logic [CHANNELS*2-1:0]           mode,
  output logic [CHANNELS*WIDTH-1:0]       wave,
  output logic                            sample_valid,
  output logic                            busy,
  output logic                            overrun
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int unsigned CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Only the top phase bits ever reach a waveform, so snapshots keep just those.
  localparam int unsigned SW    = (ADDRESS_WIDTH + 2 > WIDTH + 1) ? ADDRESS_WIDTH + 2 : WIDTH + 1;
  localparam logic [WIDTH-1:0] MID = WIDTH'(1) << (WIDTH - 1);
  localparam longint MAX_MAG     = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint PI_HALF_Q30 = 64'sd1686629713;

  // round(MAX_MAG * sin(pi/2 * k / DEPTH)) via Q30 Taylor series, evaluated at elaboration.
  function automatic logic [WIDTH-2:0] rom_entry(input int unsigned k);
    longint x;
    longint x2;
    longint term;
    longint acc;
    x    = (PI_HALF_Q30 * longint'(k)) >>> ADDRESS_WIDTH;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      acc  = acc + term;
    end
    rom_entry = (WIDTH-1)'((MAX_MAG * acc + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic [WIDTH-2:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [WIDTH-2:0] ENTRY = rom_entry(k);
    assign rom[k] = ENTRY;
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [PHASE_WIDTH-1:0] acc      [CHANNELS];
  logic [PHASE_WIDTH-1:0] acc_next [CHANNELS];
  logic [SW-1:0]          ph_next  [CHANNELS];
  logic [SW-1:0]          ph_s     [CHANNELS];
  logic [1:0]             mode_s   [CHANNELS];
  logic [WIDTH-1:0]       stage    [CHANNELS];

  logic [CW-1:0]            idx;
  logic [CW-1:0]            rom_ch;
  logic                     rom_valid;
  logic [WIDTH-2:0]         rom_q;
  logic [ADDRESS_WIDTH-1:0] addr_c;
  logic [WIDTH-1:0]         sample_c;

  logic accept_c;
  logic ignored_c;
  logic lookup_c;
  logic load_c;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next state: one LOOKUP cycle per channel, then DRAIN until the last ROM word is staged.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (enable) next_state = S_LOOKUP;
      S_LOOKUP: if (idx == CW'(CHANNELS - 1)) next_state = S_DRAIN;
      S_DRAIN:  if (!rom_valid) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // FSM decoded controls.
  always_comb begin
    accept_c  = 1'b0;
    ignored_c = 1'b0;
    lookup_c  = 1'b0;
    load_c    = 1'b0;
    case (state)
      S_IDLE:   accept_c = enable;
      S_LOOKUP: begin
        ignored_c = enable;
        lookup_c  = 1'b1;
      end
      S_DRAIN:  begin
        ignored_c = enable;
        load_c    = !rom_valid;
      end
      default:  ;
    endcase
  end

  // A phase_reset alongside acceptance zeroes the accumulator instead of adding ftw.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      acc_next[i] = phase_reset ? '0 : acc[i] + ftw[i*PHASE_WIDTH +: PHASE_WIDTH];
      ph_next[i]  = SW'((acc_next[i] + phase_offset[i*PHASE_WIDTH +: PHASE_WIDTH])
                        >> (PHASE_WIDTH - SW));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]    <= '0;
        ph_s[i]   <= '0;
        mode_s[i] <= '0;
      end
      overrun <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (phase_reset || accept_c) acc[i] <= acc_next[i];
        if (accept_c) begin
          ph_s[i]   <= ph_next[i];
          mode_s[i] <= mode[i*2 +: 2];
        end
      end
      if (phase_reset)    overrun <= 1'b0;
      else if (ignored_c) overrun <= 1'b1;
    end
  end

  // Odd quadrants walk the quarter wave backwards.
  always_comb begin
    addr_c = ph_s[idx][SW-3 -: ADDRESS_WIDTH];
    if (ph_s[idx][SW-2]) addr_c = ~ph_s[idx][SW-3 -: ADDRESS_WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      rom_ch    <= '0;
      rom_q     <= '0;
      rom_valid <= 1'b0;
    end else begin
      rom_valid <= lookup_c;
      if (accept_c)      idx <= '0;
      else if (lookup_c) idx <= idx + CW'(1);
      if (lookup_c) begin
        rom_q  <= rom[addr_c];
        rom_ch <= idx;
      end
    end
  end

  // Waveform shaping for the channel whose ROM word just arrived.
  always_comb begin
    sample_c = MID;
    case (mode_s[rom_ch])
      2'b00:   sample_c = ph_s[rom_ch][SW-1] ? MID - {1'b0, rom_q} : MID + {1'b0, rom_q};
      2'b01:   sample_c = ph_s[rom_ch][SW-1] ? '0 : '1;
      2'b10:   sample_c = ph_s[rom_ch][SW-1 -: WIDTH];
      default: sample_c = ph_s[rom_ch][SW-1] ? ~ph_s[rom_ch][SW-2 -: WIDTH]
                                             :  ph_s[rom_ch][SW-2 -: WIDTH];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) stage[i] <= MID;
      wave         <= {CHANNELS{MID}};
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (rom_valid) stage[rom_ch] <= sample_c;
      if (load_c) begin
        for (int i = 0; i < CHANNELS; i++) wave[i*WIDTH +: WIDTH] <= stage[i];
      end
      sample_valid <= load_c;
      busy         <= (next_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_dds_multi.sv
// Self-checking bench for dds_multi: directed scenarios plus randomized samples
// compared against a phase/sine reference model.
module tb_dds_multi;
  localparam int unsigned W  = 8;
  localparam int unsigned P  = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned CH = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic            phase_reset;
  logic [CH*P-1:0] ftw;
  logic [CH*P-1:0] phase_offset;
  logic [CH*2-1:0] mode;
  logic [CH*W-1:0] wave;
  logic            sample_valid;
  logic            busy;
  logic            overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [P-1:0]    macc [CH];
  logic [CH*W-1:0] exp_w;
  logic            exp_ov;

  dds_multi #(
    .WIDTH(W), .PHASE_WIDTH(P), .ADDRESS_WIDTH(AW), .CHANNELS(CH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .phase_reset(phase_reset),
    .ftw(ftw), .phase_offset(phase_offset), .mode(mode),
    .wave(wave), .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_sample(input logic [31:0] ph, input logic [1:0] m);
    int k;
    int r;
    logic [7:0] t;
    case (m)
      2'b00: begin
        k = ph[30] ? 1023 - int'(ph[29:20]) : int'(ph[29:20]);
        r = $rtoi(127.0 * $sin(3.141592653589793 * real'(k) / 2048.0) + 0.5);
        return ph[31] ? 8'(128 - r) : 8'(128 + r);
      end
      2'b01:   return ph[31] ? 8'h00 : 8'hFF;
      2'b10:   return ph[31:24];
      default: begin
        t = ph[30:23];
        return ph[31] ? ~t : t;
      end
    endcase
  endfunction

  task automatic model_accept(input bit pr);
    for (int i = 0; i < CH; i++) begin
      macc[i] = pr ? 32'h0 : macc[i] + ftw[i*P +: P];
      exp_w[i*W +: W] = ref_sample(macc[i] + phase_offset[i*P +: P], mode[i*2 +: 2]);
    end
    if (pr) exp_ov = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < CH; i++) macc[i] = 32'h0;
    exp_ov = 1'b0;
  endtask

  // Issues one enable (held extra cycles while busy), returns pulse latency from acceptance edge.
  task automatic fire(input bit pr, input int extra, output int lat, output int pulses,
                      output logic [15:0] w, output logic bz);
    @(negedge clk);
    enable = 1'b1;
    phase_reset = pr;
    model_accept(pr);
    if (extra > 0) exp_ov = 1'b1;
    @(negedge clk);
    phase_reset = 1'b0;
    lat = -1;
    pulses = 0;
    w = 'x;
    bz = 'x;
    for (int c = 1; c <= 12; c++) begin
      enable = (c <= extra);
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          w = wave;
          bz = busy;
        end
      end
      if (lat >= 0 && c > lat) break;
    end
    enable = 1'b0;
  endtask

  task automatic pulse_phase_reset();
    @(negedge clk);
    phase_reset = 1'b1;
    @(negedge clk);
    phase_reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    int bad;
    reset_n = 1'b0;
    enable = 1'b0;
    phase_reset = 1'b0;
    ftw = '0;
    phase_offset = '0;
    mode = '0;
    model_clear();
    repeat (3) @(negedge clk);
    n_checks++;
    if (wave !== 16'h8080) begin n_fail++; $display("FAIL reset_wave: got %h want 8080", wave); end
    n_checks++;
    if ({sample_valid, busy, overrun} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got sv/busy/ov=%b want 000", {sample_valid, busy, overrun});
    end
    reset_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (sample_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL idle_quiet: %0d active cycles, want 0", bad); end
    n_checks++;
    if (wave !== 16'h8080) begin n_fail++; $display("FAIL idle_hold: got %h want 8080", wave); end
  endtask

  task automatic test_sine();
    logic [7:0] want [4] = '{8'hFF, 8'h80, 8'h01, 8'h80};
    int lat, pulses;
    logic [15:0] w;
    logic bz;
    mode = 4'b10_00;
    ftw = {32'h1357_9BDF, 32'h4000_0000};
    phase_offset = {32'($urandom), 32'h0};
    for (int i = 0; i < 4; i++) begin
      fire(1'b0, 0, lat, pulses, w, bz);
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL sine_latency[%0d]: got %0d want 4", i, lat); end
      n_checks++;
      if (w[7:0] !== want[i]) begin n_fail++; $display("FAIL sine_ch0[%0d]: got %h want %h", i, w[7:0], want[i]); end
      n_checks++;
      if (w !== exp_w) begin n_fail++; $display("FAIL sine_wave[%0d]: got %h want %h", i, w, exp_w); end
      n_checks++;
      if (pulses !== 1 || bz !== 1'b0) begin
        n_fail++; $display("FAIL sine_pulse[%0d]: pulses %0d busy %b want 1 0", i, pulses, bz);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_waves();
    logic [7:0] tbl [3][5];
    int cnt [3] = '{3, 5, 5};
    logic [1:0] wm [3] = '{2'b10, 2'b11, 2'b01};
    int lat, pulses;
    logic [15:0] w;
    logic bz;
    tbl[0] = '{8'h20, 8'h40, 8'h60, 8'h00, 8'h00};
    tbl[1] = '{8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    for (int m = 0; m < 3; m++) begin
      pulse_phase_reset();
      ftw = {32'h2000_0000, 32'($urandom)};
      phase_offset = {32'h0, 32'($urandom)};
      mode = {wm[m], 2'($urandom)};
      for (int i = 0; i < cnt[m]; i++) begin
        fire(1'b0, 0, lat, pulses, w, bz);
        n_checks++;
        if (w[15:8] !== tbl[m][i]) begin
          n_fail++; $display("FAIL wave_mode%0d[%0d]: ch1 got %h want %h", wm[m], i, w[15:8], tbl[m][i]);
        end
        n_checks++;
        if (w !== exp_w) begin n_fail++; $display("FAIL wave_model%0d[%0d]: got %h want %h", wm[m], i, w, exp_w); end
      end
    end
  endtask

  task automatic test_overrun();
    int lat, pulses;
    logic [15:0] w;
    logic bz;
    pulse_phase_reset();
    ftw = {32'($urandom) | 32'h1, 32'($urandom) | 32'h1};
    phase_offset = {32'($urandom), 32'($urandom)};
    mode = 4'($urandom);
    fire(1'b0, 1, lat, pulses, w, bz);
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d want 1", pulses); end
    n_checks++;
    if (w !== exp_w) begin n_fail++; $display("FAIL overrun_wave: got %h want %h", w, exp_w); end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
    fire(1'b0, 0, lat, pulses, w, bz);
    n_checks++;
    if (w !== exp_w) begin n_fail++; $display("FAIL overrun_acc_once: got %h want %h", w, exp_w); end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    pulse_phase_reset();
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    fire(1'b0, 0, lat, pulses, w, bz);
    n_checks++;
    if (w !== exp_w) begin n_fail++; $display("FAIL acc_cleared: got %h want %h", w, exp_w); end
  endtask

  task automatic test_phase_reset_enable();
    int lat, pulses;
    logic [15:0] w;
    logic bz;
    ftw = {32'($urandom), 32'($urandom)};
    phase_offset = {32'($urandom), 32'h4000_0000};
    mode = {2'($urandom), 2'b00};
    fire(1'b1, 0, lat, pulses, w, bz);
    n_checks++;
    if (w[7:0] !== 8'hFF) begin n_fail++; $display("FAIL pr_enable_ch0: got %h want ff", w[7:0]); end
    n_checks++;
    if (w !== exp_w) begin n_fail++; $display("FAIL pr_enable_wave: got %h want %h", w, exp_w); end
    ftw[31:0] = 32'h0;
    fire(1'b0, 0, lat, pulses, w, bz);
    n_checks++;
    if (w[7:0] !== 8'hFF) begin n_fail++; $display("FAIL pr_hold_ch0: got %h want ff", w[7:0]); end
  endtask

  task automatic test_random();
    int lat, pulses, extra;
    bit pr;
    logic [15:0] w;
    logic bz;
    for (int it = 0; it < 24; it++) begin
      ftw = {32'($urandom), 32'($urandom)};
      phase_offset = {32'($urandom), 32'($urandom)};
      mode = 4'($urandom);
      pr = ($urandom_range(0, 3) == 0);
      extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      fire(pr, extra, lat, pulses, w, bz);
      n_checks++;
      if (lat !== 4 || pulses !== 1) begin
        n_fail++; $display("FAIL rand_timing[%0d]: lat %0d pulses %0d want 4 1", it, lat, pulses);
      end
      n_checks++;
      if (w !== exp_w) begin n_fail++; $display("FAIL rand_wave[%0d]: got %h want %h", it, w, exp_w); end
      n_checks++;
      if (overrun !== exp_ov || bz !== 1'b0) begin
        n_fail++; $display("FAIL rand_flags[%0d]: ov %b busy %b want %b 0", it, overrun, bz, exp_ov);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int lat, pulses, seen;
    logic [15:0] w;
    logic bz;
    ftw = {32'($urandom), 32'($urandom)};
    phase_offset = {32'h0, 32'h4000_0000};
    mode = 4'b01_00;
    fire(1'b1, 0, lat, pulses, w, bz);
    n_checks++;
    if (w !== 16'hFFFF) begin n_fail++; $display("FAIL pre_reset_wave: got %h want ffff", w); end
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (wave !== 16'h8080) begin n_fail++; $display("FAIL inflight_reset_wave: got %h want 8080", wave); end
    n_checks++;
    if ({sample_valid, busy, overrun} !== 3'b000) begin
      n_fail++; $display("FAIL inflight_reset_flags: got %b want 000", {sample_valid, busy, overrun});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (sample_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL inflight_abandoned: %0d pulses want 0", seen); end
    fire(1'b0, 0, lat, pulses, w, bz);
    n_checks++;
    if (w !== exp_w || lat !== 4) begin
      n_fail++; $display("FAIL post_reset_sample: got %h lat %0d want %h 4", w, lat, exp_w);
    end
  endtask

  initial begin
    test_reset();
    test_sine();
    test_waves();
    test_overrun();
    test_phase_reset_enable();
    test_random();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
